// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and BCD digit helpers
package bcd_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OP   = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic dig_invalid(input logic [3:0] d);
        return d > 4'd9;
    endfunction

    // A digit at 8 or more after a right shift carried a decimal ten into the lower digit.
    function automatic logic [3:0] dig_corr(input logic [3:0] d);
        return (d >= 4'd8) ? d - 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_dig_shift.sv
// rtl/bcd_dig_shift.sv - one BCD digit: shift right by one bit, then correct
module bcd_dig_shift
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       bit_in,
    output logic [3:0] digit_out,
    output logic       bit_out
);

    logic [3:0] shifted;

    assign shifted   = {bit_in, digit[3:1]};
    assign digit_out = dig_corr(shifted);
    assign bit_out   = digit[0];

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential reverse double-dabble BCD to binary converter
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int NDIG = 6,
    parameter int BW   = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                ready,
    output logic                done_tick,
    output logic [BW-1:0]       bin,
    output logic                err
);

    localparam int NW = $clog2(BW + 1);

    logic [1:0]          state;
    logic [4*NDIG-1:0]   dig_q;
    logic [4*NDIG-1:0]   dig_next;
    logic [BW-1:0]       shift_q;
    logic [BW-1:0]       shift_next;
    logic [NW-1:0]       n_q;
    logic [NDIG:0]       link;
    logic                bad_in;

    // link[k] is the bit leaving digit k; the top digit is fed zeros.
    assign link[NDIG] = 1'b0;

    genvar k;
    generate
        for (k = 0; k < NDIG; k++) begin : g_dig
            bcd_dig_shift u_dig (
                .digit     (dig_q[4*k +: 4]),
                .bit_in    (link[k+1]),
                .digit_out (dig_next[4*k +: 4]),
                .bit_out   (link[k])
            );
        end
    endgenerate

    assign shift_next = {link[0], shift_q[BW-1:1]};

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_invalid(bcd_in[4*i +: 4])) bad_in = 1'b1;
        end
    end

    assign ready     = (state == ST_IDLE);
    assign done_tick = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            dig_q   <= '0;
            shift_q <= '0;
            n_q     <= '0;
            bin     <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dig_q   <= bcd_in;
                        shift_q <= '0;
                        n_q     <= NW'(BW);
                        if (bad_in) begin
                            state <= ST_DONE;
                            bin   <= '0;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_OP;
                        end
                    end
                end
                ST_OP: begin
                    dig_q   <= dig_next;
                    shift_q <= shift_next;
                    n_q     <= n_q - NW'(1);
                    if (n_q == NW'(1)) begin
                        state <= ST_DONE;
                        bin   <= shift_next;
                        err   <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - scoreboard bench for bcd_to_bin
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] bcd_in = '0;
    logic        ready;
    logic        done_tick;
    logic [19:0] bin;
    logic        err;

    typedef struct {
        logic [19:0] bin;
        logic        err;
        int          lat;
        int          scyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    bcd_to_bin #(.NDIG(6), .BW(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .ready     (ready),
        .done_tick (done_tick),
        .bin       (bin),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done_tick must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done_tick) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done_tick), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("bin", 32'(bin), 32'(e.bin));
                    chk("err", 32'(err), 32'(e.err));
                    chk("latency", 32'(cyc - e.scyc + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic launch(input logic [23:0] v, input logic expect_it,
                          input logic [19:0] eb, input logic ee, input int lat);
        exp_t e;
        wait_ready();
        bcd_in = v;
        start  = 1'b1;
        if (expect_it) begin
            e.bin = eb; e.err = ee; e.lat = lat; e.scyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        if (lat > 1) chk("ready_drop", 32'(ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done_tick), 32'd0);
        chk("rst_bin", 32'(bin), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        launch(24'h000255, 1'b1, 20'h000FF, 1'b0, 21); drain();
        launch(24'h999999, 1'b1, 20'hF423F, 1'b0, 21); drain();
        launch(24'h000000, 1'b1, 20'h00000, 1'b0, 21); drain();
        launch(24'h000001, 1'b1, 20'h00001, 1'b0, 21); drain();
        repeat (5) @(negedge clk);
        chk("bin_hold_idle", 32'(bin), 32'd1);

        launch(24'h00A123, 1'b1, 20'h00000, 1'b1, 1); drain();
        launch(24'h000010, 1'b1, 20'h0000A, 1'b0, 21); drain();

        // Extra start and new bcd_in during op must not disturb the latched value.
        launch(24'h000255, 1'b1, 20'h000FF, 1'b0, 21);
        repeat (3) @(negedge clk);
        chk("bin_hold_op", 32'(bin), 32'h0000A);
        bcd_in = 24'h999999;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 24'h000777;
        drain();
        repeat (25) @(negedge clk);

        // Abort at op cycle 10: no expectation pushed, so any done_tick flags.
        launch(24'h123456, 1'b0, 20'h0, 1'b0, 21);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_bin", 32'(bin), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_done", 32'(done_tick), 32'd0);
        reset = 1'b0;
        repeat (25) @(negedge clk);

        launch(24'h123456, 1'b1, 20'h1E240, 1'b0, 21); drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every digit that is 8 or more. It is the inverse of the counter's binary-to-BCD path. It takes operator- or host-entered decimal values (gate time, scale thresholds) and turns them into binary for the counter datapath. It uses the same start/ready/done_tick handshake as the rest of the counter FSMDs.

Parameters:
NDIG, 6, number of BCD input digits.
BW, 20, binary output width and iteration count. Constraint: 2^BW > 10^NDIG - 1. The defaults satisfy it, since 999999 < 1048576.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request conversion; sampled only while ready=1
bcd_in  in  4*NDIG  packed BCD digits; digit 0 is bits [3:0]
ready  out  1  high in idle only, combinational from state
done_tick  out  1  one-cycle pulse in the done state
bin  out  BW  registered result; held until the next conversion completes
err  out  1  registered; 1 if the last accepted bcd_in had any digit above 9

Behaviour:
- Reset (synchronous, active-high): state=idle, bin=0, err=0, internal digit/shift/count registers=0. ready=1 and done_tick=0 after reset.
- Reset asserted mid-operation aborts the conversion: next cycle idle, bin=0, err=0, no done_tick.
- States: idle, op, done; unused encodings go to idle.
- idle:
  - ready=1.
  - On start=1, latch bcd_in into NDIG digit registers, clear the BW-bit shift register, set n=BW.
  - If any latched digit is above 9, go to done with err_next=1 and a pending result of 0.
  - Otherwise go to op with err_next=0.
- op, one iteration per cycle:
  - shift_next = {digit0[0], shift[BW-1:1]}.
  - The digit chain shifts right one bit: digit k receives digit k+1's LSB in bit 3, and the top digit receives 0.
  - Each shifted digit d: if d >= 8 then d-3, else d.
  - n decrements by 1; when n_next==0, go to done.
  - op lasts exactly BW cycles.
- done:
  - done_tick=1 for one cycle, then idle.
  - bin and err update on the clock edge entering done, so bin is already valid in the done_tick cycle.
  - bin gets shift_next on the normal path and 0 on the error path.
- Latency: start sampled at edge T. Normal path: op for cycles T+1..T+BW, done_tick at cycle T+BW+1, ready again at T+BW+2. Error path: done_tick at T+1.
- start while not idle is ignored; no queuing.
- start held high continuously restarts a conversion in each idle cycle.
- bcd_in is sampled only at start acceptance; later changes do not affect the result.
- bin never shows intermediate values; it changes only on entry to done.
- Arithmetic: the digit correction is 4-bit unsigned. A digit after shifting never exceeds 15, and a corrected digit never wraps because it is at least 8 before subtracting 3. n is $clog2(BW+1) bits wide.
- Leading-zero and all-zero inputs are legal.

Decomposition:
- Shared package bcd_pkg holds:
  - state encoding localparams (idle=2'b00, op=2'b01, done=2'b10);
  - the function dig_invalid(d) (d>9);
  - the function dig_corr(d) (d>=8 ? d-3 : d), shared with a future bin_to_bcd refactor.
- One natural sub-module: bcd_dig_shift. It is combinational, takes a 4-bit digit and the incoming bit, and outputs the corrected digit and the outgoing LSB. It is instantiated NDIG times with generate.
- The FSM, counter, shift register and output registers stay in bcd_to_bin.

Test Plan:
- Reset, then start with bcd_in=24'h000255 -> ready drops; done_tick exactly 21 cycles after the start edge; bin=20'h000FF, err=0.
- bcd_in=24'h999999 -> bin=20'hF423F (999999), err=0.
- bcd_in=24'h000000, then separately 24'h000001 -> bin=0, then bin=1. Also check that bin holds its value between conversions.
- bcd_in=24'h00A123 (digit 3 = 0xA) -> done_tick one cycle after start, err=1, bin=0. The next valid conversion of 24'h000010 clears err and gives bin=10.
- start pulsed again during op, and bcd_in changed during op -> the result is for the originally latched value. The extra start is ignored, with a single done_tick.
- reset asserted at op cycle 10 -> idle next cycle, bin=0, err=0, no done_tick. A fresh start of 24'h123456 -> bin=20'h1E240.
